// File: rtl/carpark_pkg.sv
// Shared types for the car-park gate decoder: FSM state encoding and {b,a} sensor patterns.
package carpark_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        E1    = 3'd1,
        E2    = 3'd2,
        E3    = 3'd3,
        X1    = 3'd4,
        X2    = 3'd5,
        X3    = 3'd6,
        ABORT = 3'd7
    } state_t;

    localparam logic [1:0] PAT_NONE = 2'b00;
    localparam logic [1:0] PAT_A    = 2'b01;
    localparam logic [1:0] PAT_B    = 2'b10;
    localparam logic [1:0] PAT_BOTH = 2'b11;

endpackage

// File: rtl/carpark_occupancy_if.sv
// Gate-sensor input and occupancy/status outputs; master = sensor/display side, slave = decoder.
interface carpark_occupancy_if #(
    parameter int WIDTH = 4
);
    logic [1:0]       btn;
    logic [WIDTH-1:0] count;
    logic [2:0]       debug_state;
    logic             inc_pulse;
    logic             dec_pulse;
    logic             err_pulse;

    modport master (
        output btn,
        input  count, debug_state, inc_pulse, dec_pulse, err_pulse
    );

    modport slave (
        input  btn,
        output count, debug_state, inc_pulse, dec_pulse, err_pulse
    );
endinterface

// File: rtl/carpark_occupancy_debouncer.sv
// 2-flop synchronizer plus optional stability filter (CARPARK_DEBOUNCE_EN); latency 2 or 2+CYCLES.
// No backpressure: a new pattern is published only after it has been stable long enough.
module sensor_debouncer #(
    parameter int WIDTH  = 2,
    parameter int CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] pat_o
);

    if (CYCLES < 1) begin : g_bad_cycles
        $error("sensor_debouncer: CYCLES must be >= 1");
    end

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef CARPARK_DEBOUNCE_EN
    localparam int CntW = $clog2(CYCLES + 1);

    logic [WIDTH-1:0] pat_q, pat_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [CntW:0]    run_len;

    // run_len counts the current cycle, so a candidate seen for CYCLES edges is accepted on the last one
    always_comb begin
        pat_d   = pat_q;
        cand_d  = sync2_q;
        cnt_d   = '0;
        run_len = (sync2_q == cand_q) ? ({1'b0, cnt_q} + (CntW+1)'(1)) : (CntW+1)'(1);
        if (sync2_q != pat_q) begin
            if (run_len >= (CntW+1)'(CYCLES)) begin
                pat_d = sync2_q;
            end else begin
                cnt_d = run_len[CntW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q  <= '0;
            cand_q <= '0;
            cnt_q  <= '0;
        end else begin
            pat_q  <= pat_d;
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pat_o = pat_q;
`else
    assign pat_o = sync2_q;
`endif

endmodule

// File: rtl/carpark_occupancy.sv
// Decodes gate sequences {b,a} into entry/exit events with a saturating count; macro CARPARK_DEBOUNCE_EN.
// Latency btn->outputs: 3 cycles (2+DEBOUNCE_CYCLES+1 with the filter); no backpressure.
module carpark_occupancy
    import carpark_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int MAX_COUNT       = 15,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    carpark_occupancy_if.slave  bus
);

    if (MAX_COUNT > (2**WIDTH - 1)) begin : g_bad_max
        $error("carpark_occupancy: MAX_COUNT does not fit in WIDTH bits");
    end

    localparam logic [WIDTH-1:0] MaxCnt = WIDTH'(MAX_COUNT);

    logic [1:0]       pat;
    logic [1:0]       p_last_q;
    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic             inc_q;
    logic             dec_q;
    logic             err_q;

    sensor_debouncer #(
        .WIDTH  (2),
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .raw_i (bus.btn),
        .pat_o (pat)
    );

    // Within each state the unchanged pattern never reaches the case, so the default arm is the illegal move
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            p_last_q <= PAT_NONE;
            count_q  <= '0;
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
            err_q    <= 1'b0;
            p_last_q <= pat;
            if (pat != p_last_q) begin
                unique case (state_q)
                    IDLE: begin
                        case (pat)
                            PAT_A:    state_q <= E1;
                            PAT_B:    state_q <= X1;
                            PAT_BOTH: begin state_q <= ABORT; err_q <= 1'b1; end
                            default:  state_q <= IDLE;
                        endcase
                    end
                    E1: begin
                        case (pat)
                            PAT_BOTH: state_q <= E2;
                            PAT_NONE: state_q <= IDLE;
                            default:  begin state_q <= ABORT; err_q <= 1'b1; end
                        endcase
                    end
                    E2: begin
                        case (pat)
                            PAT_B:   state_q <= E3;
                            PAT_A:   state_q <= E1;
                            default: begin state_q <= ABORT; err_q <= 1'b1; end
                        endcase
                    end
                    E3: begin
                        case (pat)
                            PAT_NONE: begin
                                state_q <= IDLE;
                                if (count_q == MaxCnt) begin
                                    err_q <= 1'b1;
                                end else begin
                                    count_q <= count_q + WIDTH'(1);
                                    inc_q   <= 1'b1;
                                end
                            end
                            PAT_BOTH: state_q <= E2;
                            default:  begin state_q <= ABORT; err_q <= 1'b1; end
                        endcase
                    end
                    X1: begin
                        case (pat)
                            PAT_BOTH: state_q <= X2;
                            PAT_NONE: state_q <= IDLE;
                            default:  begin state_q <= ABORT; err_q <= 1'b1; end
                        endcase
                    end
                    X2: begin
                        case (pat)
                            PAT_A:   state_q <= X3;
                            PAT_B:   state_q <= X1;
                            default: begin state_q <= ABORT; err_q <= 1'b1; end
                        endcase
                    end
                    X3: begin
                        case (pat)
                            PAT_NONE: begin
                                state_q <= IDLE;
                                if (count_q == '0) begin
                                    err_q <= 1'b1;
                                end else begin
                                    count_q <= count_q - WIDTH'(1);
                                    dec_q   <= 1'b1;
                                end
                            end
                            PAT_BOTH: state_q <= X2;
                            default:  begin state_q <= ABORT; err_q <= 1'b1; end
                        endcase
                    end
                    ABORT: begin
                        if (pat == PAT_NONE) begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.count       = count_q;
    assign bus.debug_state = state_q;
    assign bus.inc_pulse   = inc_q;
    assign bus.dec_pulse   = dec_q;
    assign bus.err_pulse   = err_q;

endmodule
